// File: rtl/aes_pkg.sv
// AES shared types, S-box and byte-level round helpers (SubBytes, ShiftRows, MixColumns).
// Latency: none, every function is purely combinational.
// Backpressure: not applicable, the package holds no state.
package aes_pkg;

    localparam int RK_IDX_W = 4;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_t;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state lives at [127-8i -: 8]; byte index is row + 4*column.
    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        aes_byte_t  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Latency: combinational, zero cycles.
// Backpressure: none, output follows inputs.
module aes_round_comb
    import aes_pkg::*;
(
    input  aes_state_t state_in,
    input  aes_state_t rk,
    input  logic       is_final,
    output aes_state_t state_out
);

    aes_state_t shifted;

    assign shifted   = shift_rows(sub_bytes(state_in));
    assign state_out = (is_final ? shifted : mix_columns(shifted)) ^ rk;

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per cycle, round keys fetched by index from an external source.
// Latency: out_valid rises NR cycles after the accepting edge; one block per NR+2 cycles at best.
// Backpressure: in_ready low outside IDLE; ciphertext held stable until out_ready.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic [RK_IDX_W-1:0] rk_idx,
    input  logic [127:0]        rk_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
        $error("aes_cipher_iter: NR must be 10, 12 or 14");
    end

    aes_fsm_t            fsm_q, fsm_d;
    logic [RK_IDX_W-1:0] cnt_q, cnt_d;
    aes_state_t          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    aes_state_t          out_data_q, out_data_d;
    logic                busy_q, busy_d;

    aes_state_t round_out;
    logic       last_rnd;

    assign last_rnd = (cnt_q == RK_IDX_W'(NR));

    aes_round_comb u_round (
        .state_in  (state_q),
        .rk        (rk_in),
        .is_final  (last_rnd),
        .state_out (round_out)
    );

    // Key index is a decode of registered state only, so the key source sees a clean address.
    assign rk_idx    = (fsm_q == ST_RUN) ? cnt_q : '0;
    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ rk_in;
                    cnt_d   = RK_IDX_W'(1);
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_out;
                if (last_rnd) begin
                    fsm_d       = ST_DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = round_out;
                end else begin
                    cnt_d = cnt_q + RK_IDX_W'(1);
                end
            end
            ST_DONE: begin
                // An in_valid seen here is deliberately not taken; IDLE accepts it next cycle.
                if (out_ready) begin
                    fsm_d       = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
        busy_d = (fsm_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter (NR=10 and NR=14) and the standalone round datapath.
// Round keys come from the bench's own key expansion over a computed (inverse+affine) S-box.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int n_vec = 0;
    int n_err = 0;

    // NR=10 instance
    logic         in_valid10, in_ready10, out_valid10, out_ready10, busy10;
    logic [127:0] in_data10, rk_in10, out_data10;
    logic [3:0]   rk_idx10;
    logic [127:0] rk10 [0:15];
    assign rk_in10 = rk10[rk_idx10];

    // NR=14 instance
    logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
    logic [127:0] in_data14, rk_in14, out_data14;
    logic [3:0]   rk_idx14;
    logic [127:0] rk14 [0:15];
    assign rk_in14 = rk14[rk_idx14];

    // standalone round
    logic [127:0] rc_state, rc_rk, rc_out;
    logic         rc_final;

    aes_cipher_iter #(.NR(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_data(in_data10), .rk_idx(rk_idx10), .rk_in(rk_in10), .out_valid(out_valid10),
        .out_ready(out_ready10), .out_data(out_data10), .busy(busy10)
    );

    aes_cipher_iter #(.NR(14)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14),
        .in_data(in_data14), .rk_idx(rk_idx14), .rk_in(rk_in14), .out_valid(out_valid14),
        .out_ready(out_ready14), .out_data(out_data14), .busy(busy14)
    );

    aes_round_comb u_rc (
        .state_in(rc_state), .rk(rc_rk), .is_final(rc_final), .state_out(rc_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] tb_sbox(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {tb_sbox(v[31:24]), tb_sbox(v[23:16]), tb_sbox(v[15:8]), tb_sbox(v[7:0])};
    endfunction

    logic [31:0] w [0:59];

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    // From the cycle after an accepting edge: step through rounds 1..10, then expect the result.
    task automatic run_rounds10(input string tag);
        for (int r = 1; r <= 10; r++) begin
            chk({tag, "_rk_idx"}, {124'h0, rk_idx10}, r);
            chk({tag, "_no_early_valid"}, {127'h0, out_valid10}, 0);
            tick();
        end
        chk({tag, "_out_valid"}, {127'h0, out_valid10}, 1);
        chk({tag, "_out_data"}, out_data10, CT_B);
    endtask

    task automatic run_appb10(input string tag);
        in_data10  = PT_B;
        in_valid10 = 1'b1;
        chk({tag, "_in_ready"}, {127'h0, in_ready10}, 1);
        chk({tag, "_rk_idx0"}, {124'h0, rk_idx10}, 0);
        tick();
        in_valid10 = 1'b0;
        run_rounds10(tag);
    endtask

    int acc_cyc[$];
    int nres;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rk10[i] = '0;
            rk14[i] = '0;
        end
        expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        for (int i = 0; i <= 10; i++) rk10[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        for (int i = 0; i <= 14; i++) rk14[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};

        rst_n = 1'b0;
        in_valid10 = 1'b0; in_data10 = '0; out_ready10 = 1'b0;
        in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
        rc_state = '0; rc_rk = '0; rc_final = 1'b0;
        #2;
        chk("rst_in_ready", {127'h0, in_ready10}, 1);
        chk("rst_out_valid", {127'h0, out_valid10}, 0);
        chk("rst_out_data", out_data10, 0);
        chk("rst_rk_idx", {124'h0, rk_idx10}, 0);
        chk("rst_busy", {127'h0, busy10}, 0);

        // standalone round datapath, App B round 1 and final round
        rc_state = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        rc_rk    = 128'ha0fafe1788542cb123a339392a6c7605;
        rc_final = 1'b0;
        #1;
        chk("round_mix", rc_out, 128'ha49c7ff2689f352b6b5bea43026a5049);
        rc_state = 128'heb40f21e592e38848ba113e71bc342d2;
        rc_rk    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rc_final = 1'b1;
        #1;
        chk("round_final", rc_out, CT_B);

        tick();
        rst_n = 1'b1;
        tick();

        // App B, NR=10: latency and key index sequence
        run_appb10("appb");
        chk("appb_busy", {127'h0, busy10}, 1);

        // backpressure in DONE with a pending plaintext
        in_data10  = PT_B;
        in_valid10 = 1'b1;
        out_ready10 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", {127'h0, out_valid10}, 1);
            chk("bp_out_data", out_data10, CT_B);
            chk("bp_in_ready", {127'h0, in_ready10}, 0);
            chk("bp_rk_idx", {124'h0, rk_idx10}, 0);
        end
        out_ready10 = 1'b1;
        tick();
        out_ready10 = 1'b0;
        chk("bp_release_valid", {127'h0, out_valid10}, 0);
        chk("bp_release_in_ready", {127'h0, in_ready10}, 1);
        chk("bp_no_accept_on_handshake", {127'h0, busy10}, 0);
        tick();
        in_valid10 = 1'b0;
        chk("bp_next_accept_busy", {127'h0, busy10}, 1);
        run_rounds10("bp_block");
        out_ready10 = 1'b1;
        tick();
        out_ready10 = 1'b0;
        chk("bp_back_idle", {127'h0, in_ready10}, 1);

        // reset in the middle of round 5
        in_data10  = PT_B;
        in_valid10 = 1'b1;
        tick();
        in_valid10 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_round5", {124'h0, rk_idx10}, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {127'h0, out_valid10}, 0);
        chk("midrst_rk_idx", {124'h0, rk_idx10}, 0);
        chk("midrst_in_ready", {127'h0, in_ready10}, 1);
        chk("midrst_busy", {127'h0, busy10}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_appb10("post_rst");
        out_ready10 = 1'b1;
        tick();
        out_ready10 = 1'b0;

        // back-to-back, in_valid and out_ready held high
        out_ready10 = 1'b1;
        in_valid10  = 1'b1;
        in_data10   = PT_B;
        nres = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (in_ready10 && in_valid10) acc_cyc.push_back(cyc);
            if (out_valid10 && out_ready10) begin
                chk("b2b_out_data", out_data10, CT_B);
                nres++;
            end
            tick();
        end
        in_valid10 = 1'b0;
        chk("b2b_accepts", acc_cyc.size(), 4);
        chk("b2b_results", nres, 3);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 12);
        end

        // NR=14, FIPS-197 C.3
        in_data14  = PT_C3;
        in_valid14 = 1'b1;
        chk("c3_in_ready", {127'h0, in_ready14}, 1);
        tick();
        in_valid14 = 1'b0;
        for (int r = 1; r <= 14; r++) begin
            chk("c3_rk_idx", {124'h0, rk_idx14}, r);
            chk("c3_no_early_valid", {127'h0, out_valid14}, 0);
            tick();
        end
        chk("c3_out_valid", {127'h0, out_valid14}, 1);
        chk("c3_out_data", out_data14, CT_C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
Iterative AES encryption engine that generalises the single combinational encryption round into a full multi-round cipher. It reuses one round datapath per clock for NR rounds and applies a final round without MixColumns. Keys are not expanded here: the block indexes an external round-key source (key RAM or expander) with a round index. It sits between the host data path (valid/ready in and out) and the key-schedule block.

Parameters:
NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); any other value is an elaboration-time error.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  plaintext valid
in_ready  out  1  block can accept plaintext
in_data  in  128  plaintext, FIPS-197 byte order ([127:120]=byte 0, column-major state)
rk_idx  out  4  round-key index requested, 0..NR
rk_in  in  128  round key for rk_idx, combinational in the same cycle
out_valid  out  1  ciphertext valid
out_ready  in  1  downstream accepts ciphertext
out_data  out  128  ciphertext, same byte order
busy  out  1  high in RUN or DONE

Behaviour:
- Single clock; reset is asynchronous and active-low (rst_n); deassertion is synchronised outside this block.
- Reset values: FSM=IDLE, round counter=0, state register=0, out_valid=0, out_data=0, rk_idx=0, busy=0; in_ready=1 (decoded from IDLE).
- FSM states and transitions:
  - IDLE: in_ready=1, rk_idx=0. When in_valid && in_ready, load state <= in_data ^ rk_in (round 0 AddRoundKey), set counter=1, go to RUN.
  - RUN: rk_idx=counter. Each cycle, state <= round(state, rk_in, final=(counter==NR)) and counter increments. When counter==NR, go to DONE.
  - DONE: out_valid=1, out_data=state. When out_ready is high, go to IDLE.
- Round function: SubBytes, then ShiftRows, then MixColumns (skipped when final=1), then AddRoundKey.
- GF(2^8) arithmetic:
  - xtime reduces with 0x1b.
  - All byte operations are modulo 2^8, with no width growth.
- Latency and throughput:
  - out_valid rises exactly NR cycles after the accepting edge.
  - Maximum throughput is one block per NR+2 cycles: accept, NR rounds, one DONE handshake cycle.
- Handshake rules:
  - in_ready=0 in RUN and DONE. in_valid asserted there is ignored and must be held by the source.
  - While out_valid && !out_ready, out_data and out_valid stay stable.
  - If in_valid is high in the same cycle that DONE handshakes, no accept happens that cycle. The accept occurs in the following IDLE cycle.
- rk_idx is a pure decode of FSM and counter, with no glitch-relevant logic. The external source must return rk_in in the same cycle.
- Reset mid-operation discards the block immediately: out_valid=0, rk_idx=0, in_ready=1.
- Counter saturates at NR and never wraps. rk_idx never exceeds NR.

Decomposition:
- Package aes_pkg holds:
  - typedef aes_state_t (logic [127:0]) and aes_byte_t;
  - the constant SBOX[256];
  - functions xtime, sub_bytes, shift_rows, mix_columns;
  - the localparam RK_IDX_W=4.
- One sub-module, aes_round_comb (inputs state_in, rk, final; output state_out), is purely combinational and instantiated once. The FSM, counter and registers stay in aes_cipher_iter.

Test Plan:
- aes_round_comb standalone, final=0, state 193de3bea0f4e22b9ac68d2ae9f84808, rk a0fafe1788542cb123a339392a6c7605 -> a49c7ff2689f352b6b5bea43026a5049. Same block with final=1, state eb40f21e592e38848ba113e71bc342d2, rk d014f9a8c9ee2589e13f0cc8b6630ca6 -> 3925841d02dc09fbdc118597196a0b32.
- NR=10, FIPS-197 App B: plaintext 3243f6a8885a308d313198a2e0370734, bench supplies round keys from cipher key 2b7e151628aed2a6abf7158809cf4f3c -> rk_idx steps 0,1..10; out_data 3925841d02dc09fbdc118597196a0b32 with out_valid exactly 10 cycles after accept.
- NR=14, FIPS-197 C.3: plaintext 00112233445566778899aabbccddeeff, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> out_valid and out_data stable, in_ready=0, no accept. Then out_ready=1 -> IDLE, next accept one cycle later.
- Reset mid-op: assert rst_n=0 at round 5 -> out_valid=0, rk_idx=0, in_ready=1 asynchronously. A subsequent App B run gives the correct ciphertext.
- Back-to-back with out_ready=1 and in_valid=1 constantly -> accepts spaced exactly NR+2=12 cycles apart, every result correct.
